crc32_frame_checker: RTL
========================

Name: crc32_frame_checker

Overview:
Receive-side counterpart of the transmit CRC32 generator. It consumes a byte stream framed as [length byte][N payload bytes][4 CRC bytes, MSB first]. It forwards the payload bytes and accumulates the CRC-32 (poly 0x04C11DB7, MSB-first shift-in form) over every byte, including the trailing CRC. It reports frame pass/fail from the zero-residue check and aborts stalled frames with an inter-byte timeout.

Parameters:
MAX_LEN, 64, maximum legal payload length in bytes (1..255); a length byte greater than MAX_LEN is a length error.
TIMEOUT_CYCLES, 1024, number of idle clk cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
received  input  1  rx_byte valid strobe, one byte per high cycle
rx_byte  input  8  incoming byte
payload_valid  output  1  one-cycle strobe, payload_byte is a payload byte
payload_byte  output  8  forwarded payload byte
frame_done  output  1  one-cycle pulse after the 4th CRC byte is accepted
frame_ok  output  1  valid with frame_done; 1 = residue zero
frame_len_err  output  1  one-cycle pulse when the length byte exceeds MAX_LEN
frame_timeout  output  1  one-cycle pulse when an in-frame idle timeout occurs
busy  output  1  high while not in IDLE

Behaviour:
- Clock and reset: single clk domain; reset is synchronous and active-high. Reset forces state IDLE, CRC register 0, byte counters 0, idle counter 0, and all outputs 0. A reset mid-frame discards the frame and produces no frame_done.
- CRC register (32b, init 0). Per accepted byte, 8 steps, rx_byte bit7 first: reg = {reg[30:0], bit} ^ (reg[31] ? poly : 0). The register updates only on received cycles in LEN, PAYLOAD or CRC states. It clears to 0 on entry to IDLE.
- Residue rule: the frame is good iff reg == 0 after the last CRC byte. The 4 CRC bytes are the transmitter's register value after its header, payload and 4 zero bytes.
- States:
  - IDLE: received starts the frame. The byte is the length; it is fed to the CRC. If len > MAX_LEN, pulse frame_len_err next cycle and stay IDLE with the register cleared. Else latch len, then go to PAYLOAD (len > 0) or CRC (len == 0).
  - PAYLOAD: each received byte is fed to the CRC and asserts payload_valid/payload_byte on the next cycle (1-cycle latency). The payload counter increments; after the len-th byte, go to CRC.
  - CRC: each received byte is fed to the CRC; the counter counts 0..3. On the 4th byte go to DONE.
  - DONE (one cycle): frame_done = 1, frame_ok = (reg == 0), return to IDLE, clear reg. A received byte in DONE is treated as a new length byte, processed exactly as in IDLE, so back-to-back frames lose no bytes.
- frame_done, frame_ok, frame_len_err, frame_timeout and payload_valid are single-cycle pulses, 0 otherwise. frame_ok is 0 whenever frame_done is 0.
- Timeout: in PAYLOAD and CRC, the idle counter increments each cycle without received and resets to 0 on received. When the count reaches TIMEOUT_CYCLES, frame_timeout pulses, the state goes to IDLE, the register clears, and no frame_done is produced. IDLE never times out.
- Counters saturate or never wrap; the idle counter is $clog2(TIMEOUT_CYCLES+1) wide.
- busy = 1 in PAYLOAD, CRC and DONE.

Test Plan:
- Reset then bytes 00,00,00,00,00 on consecutive cycles -> no payload_valid; frame_done pulses 1 cycle after the 5th byte with frame_ok=1; busy back to 0.
- Bytes 00,00,00,00,01 -> frame_done with frame_ok=0 (nonzero residue).
- Golden frame from the transmit generator, len=3 payload A5,5A,FF plus its CRC -> payload_valid three times with A5,5A,FF each 1 cycle after input; frame_done with frame_ok=1. Flip payload bit 0 -> frame_ok=0.
- Length byte MAX_LEN+1 (65) -> frame_len_err pulse, no payload_valid, state IDLE; a following good frame passes.
- len=2, one payload byte, then TIMEOUT_CYCLES idle cycles -> frame_timeout pulses exactly on the TIMEOUT_CYCLES-th idle cycle, no frame_done. Same with TIMEOUT_CYCLES-1 idle cycles then remaining bytes -> no timeout, frame_ok=1.
- Two golden frames back-to-back with the second length byte arriving in the DONE cycle -> two frame_done pulses, both frame_ok=1. Reset asserted mid-payload -> all outputs 0 next cycle, no frame_done.

Source files
------------

// File: rtl/crc32_frame_checker_if.sv
// Byte-stream receive bus of the CRC-32 frame checker: incoming bytes plus
// forwarded payload and per-frame status pulses.
interface crc32_frame_checker_if;
    logic       received;
    logic [7:0] rx_byte;
    logic       payload_valid;
    logic [7:0] payload_byte;
    logic       frame_done;
    logic       frame_ok;
    logic       frame_len_err;
    logic       frame_timeout;
    logic       busy;

    modport master (
        output received, rx_byte,
        input  payload_valid, payload_byte, frame_done, frame_ok,
               frame_len_err, frame_timeout, busy
    );

    modport slave (
        input  received, rx_byte,
        output payload_valid, payload_byte, frame_done, frame_ok,
               frame_len_err, frame_timeout, busy
    );
endinterface

// File: rtl/crc32_frame_checker.sv
// Receive-side CRC-32 frame checker: [len][payload][4 CRC bytes], forwards the
// payload, checks for zero residue and aborts frames that stall too long.
module crc32_frame_checker #(
    parameter int MAX_LEN        = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    crc32_frame_checker_if.slave bus
);
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam int          IW   = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, CRC, DONE} state_t;

    state_t         state, state_next;
    logic [31:0]    crc;
    logic [7:0]     len;
    logic [7:0]     pay_cnt;
    logic [1:0]     crc_cnt;
    logic [IW-1:0]  idle_cnt;

    logic           start;
    logic           feed;
    logic           pv;
    logic           len_err;
    logic           tmo;

    logic           payload_valid_q;
    logic [7:0]     payload_byte_q;
    logic           frame_len_err_q;
    logic           frame_timeout_q;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = {r[30:0], b[i]} ^ (r[31] ? POLY : 32'h0);
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // DONE accepts a new length byte exactly like IDLE so back-to-back frames lose nothing.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        feed       = 1'b0;
        pv         = 1'b0;
        len_err    = 1'b0;
        tmo        = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (bus.received) begin
                    if (bus.rx_byte > 8'(MAX_LEN)) begin
                        len_err = 1'b1;
                    end else begin
                        start      = 1'b1;
                        state_next = (bus.rx_byte == 8'd0) ? CRC : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.received) begin
                    feed = 1'b1;
                    pv   = 1'b1;
                    if (pay_cnt == len - 8'd1) state_next = CRC;
                end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                    tmo        = 1'b1;
                    state_next = IDLE;
                end
            end
            CRC: begin
                if (bus.received) begin
                    feed = 1'b1;
                    if (crc_cnt == 2'd3) state_next = DONE;
                end else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                    tmo        = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            crc             <= 32'h0;
            len             <= 8'h0;
            pay_cnt         <= 8'h0;
            crc_cnt         <= 2'd0;
            idle_cnt        <= '0;
            payload_valid_q <= 1'b0;
            payload_byte_q  <= 8'h0;
            frame_len_err_q <= 1'b0;
            frame_timeout_q <= 1'b0;
        end else begin
            // The length byte always restarts the CRC from zero.
            if (start)                    crc <= crc_byte(32'h0, bus.rx_byte);
            else if (feed)                crc <= crc_byte(crc, bus.rx_byte);
            else if (state_next == IDLE)  crc <= 32'h0;

            if (start) begin
                len     <= bus.rx_byte;
                pay_cnt <= 8'h0;
                crc_cnt <= 2'd0;
            end else begin
                if (state == PAYLOAD && bus.received) pay_cnt <= pay_cnt + 8'd1;
                if (state == CRC && bus.received && crc_cnt != 2'd3) crc_cnt <= crc_cnt + 2'd1;
            end

            if ((state == PAYLOAD || state == CRC) && !bus.received && !tmo)
                idle_cnt <= idle_cnt + IW'(1);
            else
                idle_cnt <= '0;

            payload_valid_q <= pv;
            payload_byte_q  <= pv ? bus.rx_byte : 8'h0;
            frame_len_err_q <= len_err;
            frame_timeout_q <= tmo;
        end
    end

    assign bus.payload_valid = payload_valid_q;
    assign bus.payload_byte  = payload_byte_q;
    assign bus.frame_done    = (state == DONE);
    assign bus.frame_ok      = (state == DONE) && (crc == 32'h0);
    assign bus.frame_len_err = frame_len_err_q;
    assign bus.frame_timeout = frame_timeout_q;
    assign bus.busy          = (state != IDLE);
endmodule
